// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_t        - loader FSM states
//   HEADER_BYTES   - bytes in the big-endian word-count header
//   WORD_BYTES     - bytes per instruction word
//   CHECKSUM_INIT  - seed of the running XOR checksum
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COUNT_HI = 3'd1,
        S_COUNT_LO = 3'd2,
        S_DATA     = 3'd3,
        S_CHECK    = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    localparam int HEADER_BYTES = 2;
    localparam int WORD_BYTES = 4;
    localparam logic [7:0] CHECKSUM_INIT = 8'h00;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs stream bytes MSB first into 32-bit words.
//   clk, reset     - clock and synchronous active-high reset
//   clear          - restart of a load; drops any partial word
//   shift_en       - a data byte is accepted this cycle
//   byte_data      - the accepted byte
//   word_complete  - combinational pulse: this byte finishes a word
//   word           - the word including this byte, valid with word_complete
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic        word_complete,
    output logic [31:0] word
);

    logic [31:0] shift_q;
    logic [1:0]  byte_cnt;

    // The word is presented in the same cycle as its last byte so the
    // parent can register the write strobe with exactly one cycle latency.
    assign word          = {shift_q[23:0], byte_data};
    assign word_complete = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shift_q  <= word;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Frame: count_hi, count_lo (word count N), 4*N data bytes (each word MSB
// first), one checksum byte; XOR of all frame bytes must be 0x00.
//   system_clock, reset           - clock, synchronous active-high reset
//   start                         - begin a load (honoured in IDLE/DONE/ERROR)
//   byte_valid, byte_data, byte_ready - input byte stream
//   mem_write_enable, mem_address, mem_write_data - memory write port
//   cpu_hold                      - processor stall, low only once DONE
//   busy                          - load in progress
//   length_error, checksum_error  - sticky until next start or reset
//   state_dbg                     - current FSM state for observation
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_valid may drop at any time and the loader simply waits, byte_ready
// never depends on byte_valid and is high for every cycle spent in
// COUNT_HI, COUNT_LO, DATA and CHECK.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SIZE_EXP2 = 10
) (
    input  logic                 system_clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 mem_write_enable,
    output logic [SIZE_EXP2-1:0] mem_address,
    output logic [31:0]          mem_write_data,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 length_error,
    output logic                 checksum_error,
    output state_t               state_dbg
);

    state_t         state, next_state;
    logic           transfer;
    logic           start_ok;
    logic [7:0]     count_hi;
    logic [15:0]    word_count;
    logic [15:0]    header_word;
    logic [SIZE_EXP2:0] word_idx;    // one extra bit so N = depth never wraps
    logic [7:0]     xor_acc;
    logic           word_complete;
    logic [31:0]    word_value;
    logic           last_word;
    logic           set_len_err;
    logic           set_cs_err;

    assign transfer    = byte_valid && byte_ready;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign header_word = {count_hi, byte_data};
    assign last_word   = word_complete && ((32'(word_idx) + 32'd1) == 32'(word_count));
    assign busy        = (state == S_COUNT_HI) || (state == S_COUNT_LO) ||
                         (state == S_DATA) || (state == S_CHECK);
    assign state_dbg   = state;

    word_assembler u_word_assembler (
        .clk           (system_clock),
        .reset         (reset),
        .clear         (start_ok),
        .shift_en      (transfer && (state == S_DATA)),
        .byte_data     (byte_data),
        .word_complete (word_complete),
        .word          (word_value)
    );

    always_ff @(posedge system_clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        set_len_err = 1'b0;
        set_cs_err  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_COUNT_HI;
            S_COUNT_HI: if (transfer) next_state = S_COUNT_LO;
            S_COUNT_LO: begin
                if (transfer) begin
                    if (header_word == 16'd0) begin
                        next_state = S_CHECK;
                    end else if (32'(header_word) > (32'd1 << SIZE_EXP2)) begin
                        set_len_err = 1'b1;
                        next_state  = S_ERROR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: if (last_word) next_state = S_CHECK;
            S_CHECK: begin
                if (transfer) begin
                    if ((xor_acc ^ byte_data) != 8'h00) begin
                        set_cs_err = 1'b1;
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            byte_ready       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            cpu_hold         <= 1'b1;
            length_error     <= 1'b0;
            checksum_error   <= 1'b0;
            count_hi         <= '0;
            word_count       <= '0;
            word_idx         <= '0;
            xor_acc          <= CHECKSUM_INIT;
        end else begin
            // Registered from next_state so it lines up with the state itself.
            byte_ready <= (next_state == S_COUNT_HI) || (next_state == S_COUNT_LO) ||
                          (next_state == S_DATA) || (next_state == S_CHECK);
            cpu_hold         <= (state != S_DONE);
            mem_write_enable <= word_complete;
            if (word_complete) begin
                mem_address    <= word_idx[SIZE_EXP2-1:0];
                mem_write_data <= word_value;
            end
            if (transfer && (state == S_COUNT_HI)) count_hi <= byte_data;
            if (transfer && (state == S_COUNT_LO)) word_count <= header_word;
            if (start_ok) begin
                word_idx       <= '0;
                xor_acc        <= CHECKSUM_INIT;
                length_error   <= 1'b0;
                checksum_error <= 1'b0;
            end else begin
                if (word_complete) word_idx <= word_idx + 1'b1;
                if (transfer)      xor_acc <= xor_acc ^ byte_data;
                if (set_len_err)   length_error <= 1'b1;
                if (set_cs_err)    checksum_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 10;
  localparam int W  = AW + 32;

  logic          system_clock;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic          cpu_hold;
  logic          busy;
  logic          length_error;
  logic          checksum_error;
  state_t        state_dbg;

  imem_loader #(.SIZE_EXP2(AW)) dut (
    .system_clock     (system_clock),
    .reset            (reset),
    .start            (start),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .cpu_hold         (cpu_hold),
    .busy             (busy),
    .length_error     (length_error),
    .checksum_error   (checksum_error),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   tx_q[$];
  logic [31:0]  frame_words[$];
  logic [7:0]   frame_xor;
  logic         prev_we = 1'b0;
  int           overlap_cnt = 0;

  always @(negedge system_clock) begin
    if (mem_write_enable) got_q.push_back({mem_address, mem_write_data});
    if (mem_write_enable && prev_we) overlap_cnt <= overlap_cnt + 1;
    prev_we <= mem_write_enable;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s write %0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge system_clock);
    #1;
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, " start state"}, 64'(state_dbg), 64'(S_COUNT_HI));
    chk({name, " start busy"}, 64'(busy), 64'd1);
    chk({name, " start flags"}, 64'({length_error, checksum_error}), 64'd0);
    step();
    chk({name, " start cpu_hold"}, 64'(cpu_hold), 64'd1);
  endtask

  // Header plus data bytes into tx_q, expected writes into exp_q.
  task automatic build_frame(input logic [15:0] n, input bit header_only);
    logic [7:0] b;
    frame_xor = 8'h00;
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    frame_xor = n[15:8] ^ n[7:0];
    if (!header_only) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 3; k >= 0; k--) begin
          b = frame_words[i][k*8 +: 8];
          tx_q.push_back(b);
          frame_xor = frame_xor ^ b;
        end
        exp_q.push_back({i[AW-1:0], frame_words[i]});
      end
    end
  endtask

  // Send count bytes from tx_q with 0..max_gap idle cycles before each.
  task automatic send_bytes(input int count, input int max_gap);
    int n;
    for (int j = 0; j < count && tx_q.size() > 0; j++) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) step();
      byte_valid = 1'b1;
      byte_data  = tx_q.pop_front();
      n = 0;
      while (!byte_ready && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL byte_ready timeout: got 0 expected 1");
        tx_q.delete();
        byte_valid = 1'b0;
        return;
      end
      step();
      byte_valid = 1'b0;
    end
  endtask

  task automatic check_end(input string name, input bit len_e, input bit cs_e,
                           input bit hold, input state_t st);
    step();
    chk({name, " state"}, 64'(state_dbg), 64'(st));
    chk({name, " length_error"}, 64'(length_error), 64'(len_e));
    chk({name, " checksum_error"}, 64'(checksum_error), 64'(cs_e));
    chk({name, " cpu_hold"}, 64'(cpu_hold), 64'(hold));
    chk({name, " byte_ready"}, 64'(byte_ready), 64'd0);
    chk({name, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, " state"}, 64'(state_dbg), 64'(S_IDLE));
    chk({name, " byte_ready"}, 64'(byte_ready), 64'd0);
    chk({name, " mem_write_enable"}, 64'(mem_write_enable), 64'd0);
    chk({name, " mem_address"}, 64'(mem_address), 64'd0);
    chk({name, " mem_write_data"}, 64'(mem_write_data), 64'd0);
    chk({name, " cpu_hold"}, 64'(cpu_hold), 64'd1);
    chk({name, " busy"}, 64'(busy), 64'd0);
    chk({name, " flags"}, 64'({length_error, checksum_error}), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] n;
    logic [31:0] w0, w1, w2;
    logic [7:0]  cs;
    bit          header_only;
    int          max_gap;
    bit          exp_len;
    bit          exp_cs;
    bit          exp_hold;
    state_t      exp_state;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"n2_ok",      16'h0002, 32'hDEADBEEF, 32'h01234567, 32'h0, 8'h20, 1'b0, 0, 1'b0, 1'b0, 1'b0, S_DONE};
    vecs[1] = '{"n0_ok",      16'h0000, 32'h0, 32'h0, 32'h0,              8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0, S_DONE};
    vecs[2] = '{"len_err",    16'h0401, 32'h0, 32'h0, 32'h0,              8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b1, S_ERROR};
    vecs[3] = '{"cs_err",     16'h0002, 32'hDEADBEEF, 32'h01234567, 32'h0, 8'h21, 1'b0, 0, 1'b0, 1'b1, 1'b1, S_ERROR};
    vecs[4] = '{"n3_gaps",    16'h0003, 32'h11223344, 32'hA5A55A5A, 32'h0F0F0F0F, 8'h47, 1'b0, 2, 1'b0, 1'b0, 1'b0, S_DONE};
    vecs[5] = '{"n1_ok",      16'h0001, 32'h80000001, 32'h0, 32'h0,        8'h80, 1'b0, 0, 1'b0, 1'b0, 1'b0, S_DONE};

    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      frame_words.delete();
      frame_words.push_back(vecs[v].w0);
      frame_words.push_back(vecs[v].w1);
      frame_words.push_back(vecs[v].w2);
      build_frame(vecs[v].n, vecs[v].header_only);
      if (!vecs[v].header_only) tx_q.push_back(vecs[v].cs);
      do_start(vecs[v].name);
      send_bytes(tx_q.size(), vecs[v].max_gap);
      check_end(vecs[v].name, vecs[v].exp_len, vecs[v].exp_cs, vecs[v].exp_hold, vecs[v].exp_state);
      check_writes(vecs[v].name);
    end

    // start pulsed in the middle of DATA must be ignored
    frame_words.delete();
    frame_words.push_back(32'hCAFEF00D);
    frame_words.push_back(32'h5EED1234);
    build_frame(16'h0002, 1'b0);
    tx_q.push_back(frame_xor);
    do_start("start_in_data");
    send_bytes(4, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_data state", 64'(state_dbg), 64'(S_DATA));
    chk("start_in_data busy", 64'(busy), 64'd1);
    send_bytes(tx_q.size(), 1);
    check_end("start_in_data", 1'b0, 1'b0, 1'b0, S_DONE);
    check_writes("start_in_data");

    // reset after 6 data bytes of a 3-word load: only word 0 survives
    frame_words.delete();
    frame_words.push_back(32'h0BADC0DE);
    frame_words.push_back(32'h77665544);
    frame_words.push_back(32'h33221100);
    build_frame(16'h0003, 1'b0);
    exp_q.delete();
    exp_q.push_back({10'd0, 32'h0BADC0DE});
    do_start("mid_reset");
    send_bytes(8, 1);
    tx_q.delete();
    reset = 1'b1;
    step();
    check_reset_values("mid_reset");
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (10) step();
    byte_valid = 1'b0;
    chk("mid_reset idle state", 64'(state_dbg), 64'(S_IDLE));
    check_writes("mid_reset");

    // full depth: 1024 words, last write at 1023
    frame_words.delete();
    for (int i = 0; i < 1024; i++)
      frame_words.push_back((32'(i) * 32'h00010001) ^ 32'h9E3779B9);
    build_frame(16'h0400, 1'b0);
    tx_q.push_back(frame_xor);
    do_start("full_depth");
    send_bytes(tx_q.size(), 0);
    check_end("full_depth", 1'b0, 1'b0, 1'b0, S_DONE);
    if (got_q.size() > 0)
      chk("full_depth last address", 64'(got_q[got_q.size()-1][W-1:32]), 64'd1023);
    check_writes("full_depth");

    chk("write strobe overlap", 64'(overlap_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
